// File: rtl/watch_timekeeper.sv
// Watch timekeeper: debounced keys, HH:MM:SS counting, 12/24-hour display,
// edit state machine and daily alarm, all outputs registered as BCD digits.
module watch_timekeeper #(
  parameter int CLK_FRE  = 27_000_000,
  parameter int DEB_CYC  = 540_000,
  parameter int MODE24   = 1,
  parameter int RING_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key,
  output logic [3:0] hour_h,
  output logic [3:0] hour_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       pm,
  output logic       sec_led,
  output logic [2:0] state_flag,
  output logic       alarm_on,
  output logic       ring
);

  localparam int PW = $clog2(CLK_FRE + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(RING_SEC + 1);

  typedef enum logic [2:0] {RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2,
                            SET_AH = 3'd3, SET_AM = 3'd4} state_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  function automatic logic [5:0] hour12(input logic [4:0] h);
    if (h == 5'd0)       return 6'd12;
    else if (h > 5'd12)  return {1'b0, h - 5'd12};
    else                 return {1'b0, h};
  endfunction

  logic [2:0]    sync1, sync2, last, level, press;
  logic [DW-1:0] deb_cnt [3];

  // Key conditioning: synchronise, then accept a level only after it held DEB_CYC cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      last  <= '1;
      level <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      last  <= sync2;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != last[i])
          deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DW'(DEB_CYC - 1))
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        if (sync2[i] == last[i] && deb_cnt[i] == DW'(DEB_CYC - 1) && last[i] != level[i]) begin
          level[i] <= last[i];
          press[i] <= ~last[i];
        end
      end
    end
  end

  state_t        state;
  logic [PW-1:0] presc;
  logic [4:0]    hour, alarm_hour;
  logic [5:0]    minute, sec, alarm_min;
  logic          alarm_en, ringing;
  logic [RW-1:0] ring_cnt;

  logic       tick, consume, mode_p, inc_p, tog_p, hold, count, alarm_en_n, alarm_hit;
  logic [5:0] min_next;
  logic [4:0] hour_next, hour_carry;

  always_comb begin
    tick       = (presc == PW'(CLK_FRE - 1));
    consume    = ringing && (press != 3'b000);
    mode_p     = press[0] && !consume;
    inc_p      = press[1] && !consume && !mode_p && (state != RUN);
    tog_p      = press[2] && !consume && !mode_p && (state == RUN);
    hold       = (state == SET_H) || (state == SET_M) || (state == RUN && mode_p);
    count      = tick && !hold;
    alarm_en_n = alarm_en ^ tog_p;
    min_next   = wrap_inc(minute, 6'd59);
    hour_next  = 5'(wrap_inc({1'b0, hour}, 6'd23));
    hour_carry = (minute == 6'd59) ? hour_next : hour;
    alarm_hit  = count && (state == RUN) && alarm_en_n && (sec == 6'd59) &&
                 (min_next == alarm_min) && (hour_carry == alarm_hour);
  end

  // Timekeeping, editing and alarm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      presc      <= '0;
      hour       <= '0;
      minute     <= '0;
      sec        <= '0;
      alarm_hour <= 5'd7;
      alarm_min  <= '0;
      alarm_en   <= 1'b0;
      ringing    <= 1'b0;
      ring_cnt   <= '0;
    end else begin
      presc <= (hold || tick) ? '0 : presc + 1'b1;

      if (state == RUN && mode_p) begin
        sec <= '0;
      end else if (count) begin
        sec <= wrap_inc(sec, 6'd59);
        if (sec == 6'd59) begin
          minute <= min_next;
          hour   <= hour_carry;
        end
      end

      if (inc_p) begin
        case (state)
          SET_H:   hour       <= hour_next;
          SET_M:   minute     <= min_next;
          SET_AH:  alarm_hour <= 5'(wrap_inc({1'b0, alarm_hour}, 6'd23));
          SET_AM:  alarm_min  <= wrap_inc(alarm_min, 6'd59);
          default: ;
        endcase
      end

      if (mode_p) begin
        case (state)
          RUN:     state <= SET_H;
          SET_H:   state <= SET_M;
          SET_M:   state <= SET_AH;
          SET_AH:  state <= SET_AM;
          default: state <= RUN;
        endcase
      end

      alarm_en <= alarm_en_n;

      if (consume || (ringing && !alarm_en_n)) begin
        ringing <= 1'b0;
      end else if (ringing && tick) begin
        ring_cnt <= ring_cnt + 1'b1;
        if (ring_cnt == RW'(RING_SEC - 1)) ringing <= 1'b0;
      end else if (alarm_hit) begin
        ringing  <= 1'b1;
        ring_cnt <= '0;
      end
    end
  end

  logic [4:0] disp_hour;
  logic [5:0] disp_min;

  always_comb begin
    disp_hour = (state == SET_AH || state == SET_AM) ? alarm_hour : hour;
    disp_min  = (state == SET_AH || state == SET_AM) ? alarm_min  : minute;
  end

  // Registered display outputs, one cycle behind the internal fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {hour_h, hour_l} <= (MODE24 != 0) ? 8'h00 : 8'h12;
      {min_h, min_l}   <= 8'h00;
      {sec_h, sec_l}   <= 8'h00;
      pm               <= 1'b0;
      sec_led          <= 1'b0;
      state_flag       <= 3'd0;
      alarm_on         <= 1'b0;
      ring             <= 1'b0;
    end else begin
      {hour_h, hour_l} <= to_bcd((MODE24 != 0) ? {1'b0, disp_hour} : hour12(disp_hour));
      {min_h, min_l}   <= to_bcd(disp_min);
      {sec_h, sec_l}   <= to_bcd(sec);
      pm               <= (MODE24 == 0) && (disp_hour >= 5'd12);
      sec_led          <= (presc < PW'(CLK_FRE / 2));
      state_flag       <= state;
      alarm_on         <= alarm_en;
      ring             <= ringing;
    end
  end

endmodule

// File: doc/watch_timekeeper.md
Name: watch_timekeeper

Overview:
Parametrised timekeeper for the 4-digit seven-segment watch. It is the successor to the fixed HH:MM data generator and keeps hours, minutes and seconds. It adds a selectable 12/24-hour mode, debounced key handling, an edit state machine and a daily alarm. Its BCD digits, blink mask and second LED feed the display controller unchanged.

Parameters:
CLK_FRE, 27_000_000, clk cycles per second; the prescaler terminal count is CLK_FRE-1.
DEB_CYC, 540_000, cycles a synchronised key level must hold before a press is accepted (20 ms at 27 MHz).
MODE24, 1, 1 = 00..23 display; 0 = 12..11 display with pm flag.
RING_SEC, 30, alarm ring duration in seconds.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
key  in  3  raw active-low keys: [0] mode, [1] increment, [2] alarm toggle / ring stop
hour_h  out  4  BCD hour tens (alarm hour in SET_AH/SET_AM)
hour_l  out  4  BCD hour units
min_h  out  4  BCD minute tens (alarm minute in SET_AH/SET_AM)
min_l  out  4  BCD minute units
sec_h  out  4  BCD second tens
sec_l  out  4  BCD second units
pm  out  1  high for internal hour 12..23 when MODE24=0; always 0 when MODE24=1
sec_led  out  1  high during the first half of each second
state_flag  out  3  edit state code for display blink
alarm_on  out  1  alarm armed
ring  out  1  alarm sounding

Behaviour:
- Reset is asynchronous and active-high. Every counter clears, the FSM goes to RUN, and the alarm time becomes 07:00.
- Output reset values: digits 0 (12h mode shows hour 12); pm=0, sec_led=0, state_flag=0, alarm_on=0, ring=0.
- Internal hour, minute, second and alarm fields are binary. All outputs are registered and update 1 cycle after the internal value.
- Keys: each key passes a 2-FF synchroniser, then a counter that reloads on any level change. An accepted falling edge gives a 1-cycle press pulse. A held key produces only one pulse. Pulses appear at DEB_CYC+3 cycles after the edge.
- Prescaler: counts 0..CLK_FRE-1 and emits a tick at CLK_FRE-1, then wraps to 0.
- sec_led = (prescaler < CLK_FRE/2).
- Timekeeping, RUN only: each tick increments sec 0..59. A wrap carries into min 0..59, and a min wrap carries into hour 0..23. 23:59:59 goes to 00:00:00.
- FSM states and codes: RUN=0, SET_H=1, SET_M=2, SET_AH=3, SET_AM=4.
  - A mode press advances RUN→SET_H→SET_M→SET_AH→SET_AM→RUN.
  - Entering SET_H clears sec and the prescaler; both stay at 0 through SET_M.
  - Counting resumes from 0 when the FSM leaves SET_M.
  - In SET_AH/SET_AM the time keeps counting in the background.
- An increment press in a SET state adds 1 to the edited field, wrapping 23→0 or 59→0, with no carry into other fields. Increment is ignored in RUN.
- Key [2]: in RUN with ring=0 it toggles alarm_on. With ring=1, a press on any key clears ring and is otherwise consumed (no toggle, no mode change). It is ignored in SET states.
- Alarm: ring sets on the tick that makes time equal alarm_hour:alarm_min:00, with alarm_on=1 and FSM in RUN. It clears after RING_SEC ticks, on a key press, or when alarm_on clears.
- 12h mapping: internal 0→12 am, 1..11→am, 12→12 pm, 13..23→1..11 pm. pm follows the field being displayed.
- Simultaneous events:
  - Mode and increment pressed in the same cycle: mode wins, increment is dropped.
  - A tick landing in the same cycle as a mode press out of RUN is dropped.
- Reset asserted mid-edit or mid-ring returns to the full reset state immediately.

Test Plan:
1. CLK_FRE=10, DEB_CYC=4, preset 23:59:58, run 20 cycles -> time reads 00:00:00, pm=0, sec_led high on cycles 0..4 of each second.
2. Press mode, hold time at 10:25 -> state_flag=1 and sec=00. Press increment 15 times -> hour 01. Mode twice more -> state_flag=3, display shows alarm 07:00.
3. Mode×2 plus increment on the alarm minute to set alarm 07:01. Return to RUN, press key[2] -> alarm_on=1. Run time from 07:00:59 -> ring=1 at 07:01:00 and ring=0 after 30 ticks.
4. While ring=1, press key[1] -> ring=0 at debounce latency, alarm_on stays 1, time unchanged.
5. MODE24=0, hour 0 then 13 -> hour_h/hour_l = 1/2 with pm=0, then 0/1 with pm=1.
6. Key bounce of 3-cycle glitches on key[0] -> no press. Assert rst mid SET_M -> all outputs at reset values within the same cycle.
